// File: rtl/parity_stream_unit_if.sv
// ============================================================================
//  Module      : parity_stream_unit_if
//  Description : Stream bundle for parity_stream_unit: input word handshake,
//                registered output word handshake and per-frame statistics.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface parity_stream_unit_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);

  // Input side (source -> unit)
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             mode;
  logic             in_parity;

  // Output side (unit -> sink)
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_parity;
  logic             out_last;
  logic             out_err;

  // Frame statistics
  logic             frame_done;
  logic             frame_parity;
  logic [CNT_W-1:0] frame_words;
  logic [CNT_W-1:0] frame_errs;

  // Environment view: drives words in, drains words out, observes statistics
  modport master (
    output in_valid, in_data, in_last, mode, in_parity, out_ready,
    input  in_ready, out_valid, out_data, out_parity, out_last, out_err,
    input  frame_done, frame_parity, frame_words, frame_errs
  );

  // Unit view
  modport slave (
    input  in_valid, in_data, in_last, mode, in_parity, out_ready,
    output in_ready, out_valid, out_data, out_parity, out_last, out_err,
    output frame_done, frame_parity, frame_words, frame_errs
  );

endinterface

`default_nettype wire

// File: rtl/parity_stream_unit.sv
// ============================================================================
//  Module      : parity_stream_unit
//  Description : Streaming parity generator/checker with one output register
//                stage and per-frame parity / word / error statistics.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module parity_stream_unit #(
  parameter int WIDTH = 8,
  parameter int ODD   = 0,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  parity_stream_unit_if.slave  bus
);

  localparam logic             c_ODD     = (ODD != 0);
  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

  // Counter increment that sticks at the all-ones value
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val,
                                               input logic             inc);
    if (inc && (val != c_CNT_MAX)) begin
      return val + c_CNT_ONE;
    end
    return val;
  endfunction

  // --------------------------------------------------------------------------
  // Registered state
  // --------------------------------------------------------------------------
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_parity;
  logic             r_out_last;
  logic             r_out_err;

  logic             r_acc_par;
  logic [CNT_W-1:0] r_acc_words;
  logic [CNT_W-1:0] r_acc_errs;

  logic             r_frame_done;
  logic             r_frame_parity;
  logic [CNT_W-1:0] r_frame_words;
  logic [CNT_W-1:0] r_frame_errs;

  // --------------------------------------------------------------------------
  // Combinational datapath
  // --------------------------------------------------------------------------
  logic             w_in_ready;
  logic             w_accept;
  logic             w_raw_par;     // plain XOR of the word, no sense applied
  logic             w_word_par;    // word parity with the configured sense
  logic             w_word_err;
  logic             w_acc_par_nxt;
  logic [CNT_W-1:0] w_words_nxt;
  logic [CNT_W-1:0] w_errs_nxt;

  // The single output slot can take a word when empty or when it drains now
  assign w_in_ready    = !r_out_valid || bus.out_ready;
  assign w_accept      = bus.in_valid && w_in_ready;

  assign w_raw_par     = ^bus.in_data;
  assign w_word_par    = w_raw_par ^ c_ODD;
  // Received parity only matters in check mode
  assign w_word_err    = bus.mode && (w_word_par != bus.in_parity);

  // Accumulator values including the word being accepted this cycle; these
  // feed both the running accumulators and the frame-close registers
  assign w_acc_par_nxt = r_acc_par ^ w_raw_par;
  assign w_words_nxt   = sat_inc(r_acc_words, 1'b1);
  assign w_errs_nxt    = sat_inc(r_acc_errs, w_word_err);

  // Output slot: load on accept, empty on drain, otherwise hold every field
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_parity <= 1'b0;
      r_out_last   <= 1'b0;
      r_out_err    <= 1'b0;
    end else if (w_accept) begin
      r_out_valid  <= 1'b1;
      r_out_data   <= bus.in_data;
      r_out_parity <= w_word_par;
      r_out_last   <= bus.in_last;
      r_out_err    <= w_word_err;
    end else if (bus.out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

  // Running frame accumulators; a closing word restarts them from zero
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc_par   <= 1'b0;
      r_acc_words <= '0;
      r_acc_errs  <= '0;
    end else if (w_accept) begin
      if (bus.in_last) begin
        r_acc_par   <= 1'b0;
        r_acc_words <= '0;
        r_acc_errs  <= '0;
      end else begin
        r_acc_par   <= w_acc_par_nxt;
        r_acc_words <= w_words_nxt;
        r_acc_errs  <= w_errs_nxt;
      end
    end
  end

  // Frame-close capture: one-cycle done pulse, statistics held until next close
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_frame_done   <= 1'b0;
      r_frame_parity <= 1'b0;
      r_frame_words  <= '0;
      r_frame_errs   <= '0;
    end else begin
      r_frame_done <= w_accept && bus.in_last;
      if (w_accept && bus.in_last) begin
        r_frame_parity <= w_acc_par_nxt ^ c_ODD;
        r_frame_words  <= w_words_nxt;
        r_frame_errs   <= w_errs_nxt;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Port drive
  // --------------------------------------------------------------------------
  assign bus.in_ready     = w_in_ready;
  assign bus.out_valid    = r_out_valid;
  assign bus.out_data     = r_out_data;
  assign bus.out_parity   = r_out_parity;
  assign bus.out_last     = r_out_last;
  assign bus.out_err      = r_out_err;
  assign bus.frame_done   = r_frame_done;
  assign bus.frame_parity = r_frame_parity;
  assign bus.frame_words  = r_frame_words;
  assign bus.frame_errs   = r_frame_errs;

endmodule

`default_nettype wire

// File: tb/tb_parity_stream_unit.sv
// ============================================================================
//  Module      : tb_parity_stream_unit
//  Description : Scoreboard bench for parity_stream_unit. Two instances:
//                even parity / 8-bit counters, and odd parity / 2-bit counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_parity_stream_unit;

  typedef struct packed {
    logic [7:0] data;
    logic       par;
    logic       last;
    logic       err;
  } word_t;

  typedef struct packed {
    logic       par;
    logic [7:0] words;
    logic [7:0] errs;
  } frame_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  int checks   = 0;
  int failures = 0;

  word_t  q_word0[$];
  word_t  q_word1[$];
  frame_t q_frame0[$];
  frame_t q_frame1[$];

  parity_stream_unit_if #(.WIDTH(8), .CNT_W(8)) b0 ();
  parity_stream_unit_if #(.WIDTH(8), .CNT_W(2)) b1 ();

  parity_stream_unit #(.WIDTH(8), .ODD(0), .CNT_W(8)) dut0 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (b0)
  );

  parity_stream_unit #(.WIDTH(8), .ODD(1), .CNT_W(2)) dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (b1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v, input logic [7:0] d,
                       input logic last, input logic md, input logic ip);
    if (sel == 0) begin
      b0.in_valid = v; b0.in_data = d; b0.in_last = last; b0.mode = md; b0.in_parity = ip;
    end else begin
      b1.in_valid = v; b1.in_data = d; b1.in_last = last; b1.mode = md; b1.in_parity = ip;
    end
  endtask

  function automatic logic rdy(input int sel);
    return (sel == 0) ? b0.in_ready : b1.in_ready;
  endfunction

  // Present one word until accepted; called and returns 1 time unit after a rising edge
  task automatic send(input int sel, input logic [7:0] d, input logic last,
                      input logic md, input logic ip, input logic exp_p,
                      input logic exp_err, input bit push);
    word_t w;
    int    waited;
    bit    done;
    w = '{data: d, par: exp_p, last: last, err: exp_err};
    if (push) begin
      if (sel == 0) q_word0.push_back(w);
      else          q_word1.push_back(w);
    end
    drive(sel, 1'b1, d, last, md, ip);
    waited = 0;
    done   = 0;
    while (!done) begin
      @(negedge clk);
      if (rdy(sel)) begin
        done = 1;
      end else begin
        waited++;
        if (waited > 50) begin
          checks++;
          failures++;
          $display("FAIL accept_timeout: word %0h never accepted (in_ready stayed 0), required accept", d);
          done = 1;
        end
      end
    end
    @(posedge clk);
    #1;
    drive(sel, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic expect_frame(input int sel, input logic par, input logic [7:0] words,
                              input logic [7:0] errs);
    frame_t f;
    f = '{par: par, words: words, errs: errs};
    if (sel == 0) q_frame0.push_back(f);
    else          q_frame1.push_back(f);
  endtask

  // Word and frame monitor for the even-parity instance
  always @(negedge clk) begin
    word_t  e;
    frame_t f;
    if (reset_n) begin
      if (b0.out_valid && b0.out_ready) begin
        checks++;
        if (q_word0.size() == 0) begin
          failures++;
          $display("FAIL word0_unexpected: got data=%h, required no output", b0.out_data);
        end else begin
          e = q_word0.pop_front();
          if (b0.out_data !== e.data || b0.out_parity !== e.par ||
              b0.out_last !== e.last || b0.out_err !== e.err) begin
            failures++;
            $display("FAIL word0: got data=%h par=%b last=%b err=%b, required data=%h par=%b last=%b err=%b",
                     b0.out_data, b0.out_parity, b0.out_last, b0.out_err, e.data, e.par, e.last, e.err);
          end
        end
      end
      if (b0.frame_done) begin
        checks++;
        if (q_frame0.size() == 0) begin
          failures++;
          $display("FAIL frame0_unexpected: got frame_done=1, required 0");
        end else begin
          f = q_frame0.pop_front();
          if (b0.frame_parity !== f.par || b0.frame_words !== f.words ||
              b0.frame_errs !== f.errs || !(b0.out_valid && b0.out_last)) begin
            failures++;
            $display("FAIL frame0: got par=%b words=%0d errs=%0d ov=%b ol=%b, required par=%b words=%0d errs=%0d ov=1 ol=1",
                     b0.frame_parity, b0.frame_words, b0.frame_errs, b0.out_valid, b0.out_last,
                     f.par, f.words, f.errs);
          end
        end
      end
    end
  end

  // Word and frame monitor for the odd-parity, 2-bit counter instance
  always @(negedge clk) begin
    word_t  e;
    frame_t f;
    if (reset_n) begin
      if (b1.out_valid && b1.out_ready) begin
        checks++;
        if (q_word1.size() == 0) begin
          failures++;
          $display("FAIL word1_unexpected: got data=%h, required no output", b1.out_data);
        end else begin
          e = q_word1.pop_front();
          if (b1.out_data !== e.data || b1.out_parity !== e.par ||
              b1.out_last !== e.last || b1.out_err !== e.err) begin
            failures++;
            $display("FAIL word1: got data=%h par=%b last=%b err=%b, required data=%h par=%b last=%b err=%b",
                     b1.out_data, b1.out_parity, b1.out_last, b1.out_err, e.data, e.par, e.last, e.err);
          end
        end
      end
      if (b1.frame_done) begin
        checks++;
        if (q_frame1.size() == 0) begin
          failures++;
          $display("FAIL frame1_unexpected: got frame_done=1, required 0");
        end else begin
          f = q_frame1.pop_front();
          if (b1.frame_parity !== f.par || {6'd0, b1.frame_words} !== f.words ||
              {6'd0, b1.frame_errs} !== f.errs) begin
            failures++;
            $display("FAIL frame1: got par=%b words=%0d errs=%0d, required par=%b words=%0d errs=%0d",
                     b1.frame_parity, b1.frame_words, b1.frame_errs, f.par, f.words, f.errs);
          end
        end
      end
    end
  end

  task automatic chk_reset_state0(input string tag);
    chk({tag, "_out_valid"},    32'(b0.out_valid),    32'd0);
    chk({tag, "_out_data"},     32'(b0.out_data),     32'd0);
    chk({tag, "_out_parity"},   32'(b0.out_parity),   32'd0);
    chk({tag, "_out_last"},     32'(b0.out_last),     32'd0);
    chk({tag, "_out_err"},      32'(b0.out_err),      32'd0);
    chk({tag, "_frame_done"},   32'(b0.frame_done),   32'd0);
    chk({tag, "_frame_parity"}, 32'(b0.frame_parity), 32'd0);
    chk({tag, "_frame_words"},  32'(b0.frame_words),  32'd0);
    chk({tag, "_frame_errs"},   32'(b0.frame_errs),   32'd0);
    chk({tag, "_in_ready"},     32'(b0.in_ready),     32'd1);
  endtask

  initial begin
    int guard;
    drive(0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    drive(1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    b0.out_ready = 1'b1;
    b1.out_ready = 1'b1;
    #1;
    chk_reset_state0("rst");
    chk("rst_in_ready1", 32'(b1.in_ready), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Even parity, generate mode, back-to-back
    expect_frame(0, 1'b1, 8'd4, 8'd0);
    send(0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    send(0, 8'h07, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1);
    send(0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1);
    send(0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1);

    // Check mode vs generate mode on 0x07
    expect_frame(0, 1'b1, 8'd3, 8'd1);
    send(0, 8'h07, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1);
    send(0, 8'h07, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1);
    send(0, 8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1);

    // Frame 0x01, 0x03 (error injected), 0x07 last
    expect_frame(0, 1'b0, 8'd3, 8'd1);
    send(0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1);
    send(0, 8'h03, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1);
    send(0, 8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1);

    // Backpressure: 0x5A held three cycles, 0x3C waits then goes through
    @(posedge clk);
    #1;
    b0.out_ready = 1'b0;
    expect_frame(0, 1'b0, 8'd2, 8'd0);
    send(0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    fork
      send(0, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1);
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("bp_in_ready",  32'(b0.in_ready),  32'd0);
          chk("bp_out_valid", 32'(b0.out_valid), 32'd1);
          chk("bp_out_data",  32'(b0.out_data),  32'h5A);
        end
        @(posedge clk);
        #1;
        b0.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready", 32'(b0.in_ready), 32'd1);
      end
    join
    @(posedge clk);
    #1;

    // Odd parity, 2-bit counters: five zero words saturate the word count
    expect_frame(1, 1'b1, 8'd3, 8'd0);
    for (int i = 0; i < 5; i++) begin
      send(1, 8'h00, (i == 4), 1'b0, 1'b0, 1'b1, 1'b0, 1);
    end
    // Four check-mode words, each with a parity error: both counters saturate
    expect_frame(1, 1'b1, 8'd3, 8'd3);
    for (int i = 0; i < 4; i++) begin
      send(1, 8'h01, (i == 3), 1'b1, 1'b1, 1'b0, 1'b1, 1);
    end
    // Single-word frame right after a saturated one starts from zero
    expect_frame(1, 1'b0, 8'd1, 8'd0);
    send(1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1);

    // Mid-frame reset with a word held in the output slot
    send(0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1);
    @(posedge clk);
    #1;
    b0.out_ready = 1'b0;
    send(0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    #2;
    chk("pre_reset_out_valid", 32'(b0.out_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    chk_reset_state0("midrst");
    @(negedge clk);
    reset_n = 1'b1;
    b0.out_ready = 1'b1;
    @(posedge clk);
    #1;
    expect_frame(0, 1'b1, 8'd1, 8'd0);
    send(0, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1);

    // Let outstanding expectations drain
    guard = 0;
    while ((q_word0.size() + q_word1.size() + q_frame0.size() + q_frame1.size()) != 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("leftover_expectations",
        32'(q_word0.size() + q_word1.size() + q_frame0.size() + q_frame1.size()), 32'd0);
    chk("final_frame_words0", 32'(b0.frame_words), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
